seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: sysclk cycles per digit slot, minimum 24.
REQ-003 SHALL have port sysclk, input, 1: the single clock; all logic rises on it.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port digits_in, input, 4*NUM_DIGITS: nibble k is digit k's value; digit 0 is rightmost.
REQ-006 SHALL have port dp_in, input, NUM_DIGITS: bit k lights digit k's decimal point.
REQ-007 SHALL have port load_valid, input, 1: the new-value request.
REQ-008 SHALL have port load_ready, output, 1: the shadow register can accept a new value.
REQ-009 SHALL have port cath, output, NUM_DIGITS: one-hot active-low digit select.
REQ-010 SHALL have ports shift, data and latch, outputs, 1 each: serial segment-register interface.
REQ-011 SHALL have port blank, output, 1: active-high output disable for the segment register.

Function
REQ-012 SHALL hold digits_in and dp_in in shadow registers, written only on a sysclk edge where load_valid and load_ready are both high.
REQ-013 SHALL drive load_ready low in the SHIFT and LATCH states and high otherwise; a load the same cycle the FSM leaves SHOW is refused.
REQ-014 SHALL run a slot counter over 0..REFRESH_DIV-1 that wraps and pulses tick for one cycle at the wrap.
REQ-015 SHALL use FSM states IDLE, SHIFT, LATCH and SHOW.
- IDLE->SHIFT on tick.
- SHIFT->LATCH after 8 bits.
- LATCH->SHOW after 1 cycle.
- SHOW->SHIFT on tick.
REQ-016 SHALL, on entering SHIFT, set blank=1 and all cath high, and increment the digit index modulo NUM_DIGITS, wrapping from NUM_DIGITS-1 to 0.
REQ-017 SHALL decode the selected shadow nibble to segment byte {dp,g,f,e,d,c,b,a}, active-high; 0..9 use standard patterns (0=0x3F, 1=0x06, 8=0x7F).
REQ-018 SHALL shift that byte MSB first at 2 cycles per bit:
- phase A: data valid, shift=0.
- phase B: shift=1, data held.
- 16 cycles total.
REQ-019 SHALL pulse latch high for exactly 1 cycle in LATCH with shift=0.
REQ-020 SHALL, in SHOW, drive cath low only on the selected digit and set blank=0.
REQ-021 SHALL take its segment byte from the shadow as sampled at SHIFT entry; later loads appear from the next slot.
REQ-022 SHALL never drive latch and shift high in the same cycle, nor blank=0 outside SHOW.
REQ-023 SHALL treat a tick arriving during SHIFT or LATCH as impossible; REFRESH_DIV>=24 guarantees this.

Reset
REQ-024 SHALL, on rst_n low, immediately set:
- cath all ones, blank=1, shift=0, data=0, latch=0.
- load_ready=1.
- shadow digits and dp to 0, digit index to NUM_DIGITS-1.
- slot counter to 0, FSM to IDLE.
REQ-025 SHALL, on reset mid-shift, abandon the transfer with no latch pulse; the first slot after release shows digit 0.

Configuration
REQ-026 SHALL, with SEG_HEX_EN defined, decode nibbles 10..15 as A,b,C,d,E,F (0x77,0x7C,0x39,0x5E,0x79,0x71).
REQ-027 SHALL, without SEG_HEX_EN, decode nibbles 10..15 as 0x00 (segments dark); the dp bit is still honoured.

Verification
REQ-028 SHALL cover reset: hold rst_n low 5 cycles -> cath=4'hF, blank=1, load_ready=1, and no latch pulse before the first tick.
REQ-029 SHALL cover a scan: load 16'h1234, dp=0, REFRESH_DIV=24 -> successive slots latch 0x66,0x4F,0x5B,0x06 with cath 1110,1101,1011,0111, repeating.
REQ-030 SHALL cover serial timing: one slot -> exactly 8 shift rising edges, data stable across each edge, then a 1-cycle latch, and blank falls the cycle after latch.
REQ-031 SHALL cover handshake: load_valid held through a SHIFT -> load_ready low for 17 cycles; the value is accepted in the first SHOW cycle and displayed from the next slot.
REQ-032 SHALL cover decode: nibble 4'hA with dp=1 -> byte 0xF7 with SEG_HEX_EN, 0x80 without.
REQ-033 SHALL cover mid-shift reset: assert rst_n after the 3rd shift edge -> outputs reach reset values the same cycle, and the next latched slot is digit 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan controller.
// Each digit slot serially shifts one segment byte {dp,g,f,e,d,c,b,a} MSB first
// into an external shift register, latches it, then enables that digit's cathode.
// Build option: define SEG_HEX_EN to decode nibbles 10..15 as A,b,C,d,E,F;
// otherwise those nibbles leave the segments dark (the decimal point still shows).
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [NUM_DIGITS-1:0]   cath,
    output logic                    shift,
    output logic                    data,
    output logic                    latch,
    output logic                    blank
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH,
        SHOW
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        slot_cnt;
    logic                    tick;
    logic [4*NUM_DIGITS-1:0] digits_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        next_idx;
    logic [3:0]              bit_cnt;
    logic [7:0]              shreg;
    logic [7:0]              seg_byte;
    logic                    leave_show;

    // Seven-segment pattern {g,f,e,d,c,b,a} for one nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
`ifdef SEG_HEX_EN
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
`endif
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign tick = (slot_cnt == CNT_W'(REFRESH_DIV - 1));

    // Slot timebase: free-running divider, tick marks the last cycle of a slot.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
        end else if (tick) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // The cycle that leaves SHOW samples the shadow for the new slot, so a load
    // landing on that same edge is refused rather than half-applied.
    assign leave_show = (state == SHOW) && tick;

    // Shadow registers written on an accepted load.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            digits_sh <= '0;
            dp_sh     <= '0;
        end else if (load_valid && load_ready && !leave_show) begin
            digits_sh <= digits_in;
            dp_sh     <= dp_in;
        end
    end

    // Next digit index and its decoded segment byte, used at slot start.
    always_comb begin
        next_idx = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        seg_byte = {dp_sh[next_idx], seg_decode(digits_sh[{next_idx, 2'b00} +: 4])};
    end

    // Scan FSM with registered outputs: blank/shift bits out/latch/show digit.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= IDX_W'(NUM_DIGITS - 1);
            bit_cnt    <= '0;
            shreg      <= '0;
            cath       <= '1;
            blank      <= 1'b1;
            shift      <= 1'b0;
            data       <= 1'b0;
            latch      <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            case (state)
                IDLE, SHOW: begin
                    if (tick) begin
                        state      <= SHIFT;
                        idx        <= next_idx;
                        shreg      <= seg_byte;
                        data       <= seg_byte[7];
                        shift      <= 1'b0;
                        bit_cnt    <= '0;
                        blank      <= 1'b1;
                        cath       <= '1;
                        load_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Even count = phase A (data set up), odd count = phase B (clock high).
                    if (!bit_cnt[0]) begin
                        shift   <= 1'b1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        shift <= 1'b0;
                        if (bit_cnt == 4'd15) begin
                            state   <= LATCH;
                            latch   <= 1'b1;
                            data    <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            shreg   <= {shreg[6:0], 1'b0};
                            data    <= shreg[6];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    state      <= SHOW;
                    latch      <= 1'b0;
                    blank      <= 1'b0;
                    cath       <= ~(NUM_DIGITS'(1) << idx);
                    load_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=24).
// The stimulus side predicts every slot's latched byte and cathode from slot
// arithmetic; a monitor rebuilds each byte from the serial pins and compares.
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int RD = 24;

    logic            sysclk = 1'b0;
    logic            rst_n;
    logic [4*N-1:0]  digits_in;
    logic [N-1:0]    dp_in;
    logic            load_valid;
    logic            load_ready;
    logic [N-1:0]    cath;
    logic            shift;
    logic            data;
    logic            latch;
    logic            blank;

    seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .cath       (cath),
        .shift      (shift),
        .data       (data),
        .latch      (latch),
        .blank      (blank)
    );

    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic [7:0]   seg;
        logic [N-1:0] cath;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc;            // rising edges since reset release
    logic [15:0] m_dig;          // model shadow
    logic [3:0]  m_dp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] ref_seg(input logic [3:0] v, input logic dp);
        logic [6:0] s;
        case (v)
            4'd0: s = 7'h3F;  4'd1: s = 7'h06;  4'd2: s = 7'h5B;  4'd3: s = 7'h4F;
            4'd4: s = 7'h66;  4'd5: s = 7'h6D;  4'd6: s = 7'h7D;  4'd7: s = 7'h07;
            4'd8: s = 7'h7F;  4'd9: s = 7'h6F;
`ifdef SEG_HEX_EN
            4'd10: s = 7'h77; 4'd11: s = 7'h7C; 4'd12: s = 7'h39;
            4'd13: s = 7'h5E; 4'd14: s = 7'h79; 4'd15: s = 7'h71;
`endif
            default: s = 7'h00;
        endcase
        return {dp, s};
    endfunction

    // Ready during the cycle after edge x: low for the 17 cycles from each slot start.
    function automatic bit model_ready(input int unsigned x);
        return !(x >= RD && (x % RD) <= 16);
    endfunction

    // One cycle of stimulus, entered and left just after a falling edge.
    task automatic step(input logic lv, input logic [15:0] d, input logic [3:0] p, output bit acc);
        int unsigned e;
        int unsigned s;
        int unsigned k;
        exp_t        ex;
        load_valid = lv;
        digits_in  = d;
        dp_in      = p;
        e = cyc + 1;
        if (e >= RD && (e % RD) == 0) begin
            s = e / RD - 1;
            k = s % N;
            ex.seg  = ref_seg(m_dig[4*k +: 4], m_dp[k]);
            ex.cath = ~(N'(1) << k);
            exp_q.push_back(ex);
        end
        acc = lv && model_ready(cyc) && !(e >= 2 * RD && (e % RD) == 0);
        if (acc) begin
            m_dig = d;
            m_dp  = p;
        end
        @(posedge sysclk);
        cyc++;
        @(negedge sysclk);
    endtask

    task automatic idle(input int unsigned n);
        bit a;
        for (int unsigned i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, a);
    endtask

    task automatic idle_until(input int unsigned phase);
        bit a;
        for (int unsigned i = 0; i < 2 * RD && !(cyc >= RD && (cyc % RD) == phase); i++)
            step(1'b0, 16'h0, 4'h0, a);
    endtask

    // Monitor: rebuild bytes from shift edges, compare at the SHOW cycle.
    initial begin
        int   nb;
        int   lr_run;
        logic [7:0] acc_b;
        logic [7:0] latched;
        logic prev_shift;
        logic prev_data;
        bit   pend_show;
        exp_t ex;
        nb = 0; lr_run = 0; acc_b = '0; latched = '0;
        prev_shift = 1'b0; prev_data = 1'b0; pend_show = 1'b0;
        forever begin
            @(negedge sysclk);
            if (!rst_n) begin
                nb = 0; lr_run = 0; acc_b = '0; pend_show = 1'b0;
                prev_shift = 1'b0; prev_data = 1'b0;
            end else begin
                if (latch && shift) check("latch_shift_overlap", 32'd1, 32'd0);
                if (!blank) check("dark_outside_show", {latch, shift, ($countones(~cath) == 1)}, 3'b001);
                if (shift && !prev_shift) begin
                    check("data_stable_at_shift", data, prev_data);
                    acc_b = {acc_b[6:0], data};
                    nb++;
                end
                if (latch) begin
                    check("shift_edges_per_slot", nb, 8);
                    check("blank_during_latch", blank, 1'b1);
                    latched   = acc_b;
                    nb        = 0;
                    pend_show = 1'b1;
                end else if (pend_show) begin
                    pend_show = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_latch", 32'd1, 32'd0);
                    end else begin
                        ex = exp_q.pop_front();
                        check("slot_seg_byte", latched, ex.seg);
                        check("slot_cath", cath, ex.cath);
                        check("blank_in_show", blank, 1'b0);
                    end
                end
                if (!load_ready) begin
                    lr_run++;
                end else if (lr_run != 0) begin
                    check("ready_low_cycles", lr_run, 17);
                    lr_run = 0;
                end
                prev_shift = shift;
                prev_data  = data;
            end
        end
    end

    initial begin
        bit a;
        int rises;
        logic prev_s;
        rst_n = 1'b0; load_valid = 1'b0; digits_in = '0; dp_in = '0;
        cyc = 0; m_dig = '0; m_dp = '0;

        repeat (5) @(negedge sysclk);
        check("rst_cath", cath, 4'hF);
        check("rst_blank", blank, 1'b1);
        check("rst_load_ready", load_ready, 1'b1);
        check("rst_shift", shift, 1'b0);
        check("rst_data", data, 1'b0);
        check("rst_latch", latch, 1'b0);
        rst_n = 1'b1;
        cyc   = 0;

        // Scan of 1234: 66,4F,5B,06 repeating.
        step(1'b1, 16'h1234, 4'h0, a);
        idle(8 * RD);

        // Load held across a SHIFT: accepted at first SHOW cycle.
        idle_until(0);
        a = 1'b0;
        for (int i = 0; i < 2 * RD && !a; i++) step(1'b1, 16'h5678, 4'b0010, a);
        // Load on the edge that leaves SHOW must be refused.
        idle_until(23);
        step(1'b1, 16'h9999, 4'hF, a);
        idle(4 * RD);

        // Hex nibble with decimal point on digit 0.
        idle_until(19);
        step(1'b1, 16'h000A, 4'b0001, a);
        idle(5 * RD);

        // Random loads.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom), a);

        // Reset after the third shift edge of a slot.
        idle_until(0);
        rises = 0; prev_s = shift;
        for (int i = 0; i < 20 && rises < 3; i++) begin
            step(1'b0, 16'h0, 4'h0, a);
            if (shift && !prev_s) rises++;
            prev_s = shift;
        end
        check("midshift_edges_seen", rises, 3);
        rst_n = 1'b0;
        #1;
        check("midrst_cath", cath, 4'hF);
        check("midrst_blank", blank, 1'b1);
        check("midrst_shift", shift, 1'b0);
        check("midrst_data", data, 1'b0);
        check("midrst_latch", latch, 1'b0);
        check("midrst_load_ready", load_ready, 1'b1);
        exp_q.delete();
        m_dig = '0;
        m_dp  = '0;
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        cyc   = 0;
        idle(2 * RD + 21);
        idle(1);
        check("all_slots_latched", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
